// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per clock behind a start/done handshake.
// Build option DIV_SIGNED_EN: two's-complement operands via magnitude pre/post conversion.

module fullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | one trial subtraction per cycle
// S_DONE | results valid, done pulsed; start here chains the next operation
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_zero_div;
    logic             w_last;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_trial_a;
    logic [WIDTH:0]   w_trial_b;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH+1:0] w_carry;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_res_q;
    logic [WIDTH-1:0] w_res_r;
    logic             w_unused;

    assign w_accept   = i_start && (r_state != S_RUN);
    assign w_zero_div = (i_divisor == '0);
    assign w_last     = (r_cnt == '0);

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    assign w_dvd_mag = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
    assign w_dvs_mag = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
            r_neg_r <= i_dividend[WIDTH-1];
        end
    end

    // most-negative / -1 falls out naturally: the magnitude quotient negates to itself
    assign w_res_q = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_res_r = r_neg_r ? -w_rem_nxt : w_rem_nxt;
`else
    assign w_dvd_mag = i_dividend;
    assign w_dvs_mag = i_divisor;
    assign w_res_q   = w_quo_nxt;
    assign w_res_r   = w_rem_nxt;
`endif

    // Trial subtract {R,Q msb} - {0,divisor} as A + ~B + 1; carry-out low means borrow
    assign w_trial_a  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial_b  = ~{1'b0, r_divisor};
    assign w_carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi = gi + 1) begin : g_sub
            fullAdder u_fa (
                .i_a   (w_trial_a[gi]),
                .i_b   (w_trial_b[gi]),
                .i_cin (w_carry[gi]),
                .o_sum (w_diff[gi]),
                .o_cout(w_carry[gi+1])
            );
        end
    endgenerate

    assign w_borrow  = ~w_carry[WIDTH+1];
    assign w_rem_nxt = w_borrow ? w_trial_a[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};
    assign w_unused  = w_diff[WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_nxt = w_zero_div ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rem         <= '0;
            r_quo         <= '0;
            r_divisor     <= '0;
            r_cnt         <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
        end else begin
            o_busy <= (w_state_nxt == S_RUN);
            o_done <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_divisor <= w_dvs_mag;
                if (w_zero_div) begin
                    o_quotient    <= '1;
                    o_remainder   <= i_dividend;
                    o_div_by_zero <= 1'b1;
                end else begin
                    r_rem         <= '0;
                    r_quo         <= w_dvd_mag;
                    r_cnt         <= CW'(WIDTH - 1);
                    o_div_by_zero <= 1'b0;
                end
            end else if (r_state == S_RUN) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                if (w_last) begin
                    o_quotient  <= w_res_q;
                    o_remainder <= w_res_r;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against an arithmetic model.
module tb_seq_divider;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic         dz;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] held_q = '0;
    logic [W-1:0] held_r = '0;

    seq_divider #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_dividend   (dividend),
        .i_divisor    (divisor),
        .o_busy       (busy),
        .o_done       (done),
        .o_quotient   (quotient),
        .o_remainder  (remainder),
        .o_div_by_zero(dz)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
`ifdef DIV_SIGNED_EN
        int sa;
        int sb;
`endif
        z = (b == '0);
        if (z) begin
            q = '1;
            r = a;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    // Issues one operation from IDLE or DONE and returns at the sample where done is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        int           n;
        int           nbusy;
        int           exp_lat;
        model(a, b, eq, er, ez);
        exp_lat  = ez ? 0 : W;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        n = 0;
        nbusy = 0;
        while (done !== 1'b1 && n < 4 * W) begin
            if (busy === 1'b1) nbusy++;
            checks++;
            if (quotient !== held_q || remainder !== held_r) begin
                errors++;
                $display("FAIL %s held_result got q=%h r=%h want q=%h r=%h", name, quotient, remainder, held_q, held_r);
            end
            tick();
            n++;
        end
        checks++;
        if (n != exp_lat) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, n, exp_lat);
        end
        checks++;
        if (nbusy != exp_lat) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d want %0d", name, nbusy, exp_lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done got %b want 0", name, busy);
        end
        checks++;
        if (quotient !== eq || remainder !== er || dz !== ez) begin
            errors++;
            $display("FAIL %s result %0d/%0d got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                     name, a, b, quotient, remainder, dz, eq, er, ez);
        end
        held_q = eq;
        held_r = er;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, dz} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL reset got busy=%b done=%b dz=%b q=%h r=%h want all 0", busy, done, dz, quotient, remainder);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_op(8'd100, 8'd7, "div_100_7");
        checks++;
        if (quotient !== 8'd14 || remainder !== 8'd2 || dz !== 1'b0) begin
            errors++;
            $display("FAIL div_100_7_const got q=%0d r=%0d dz=%b want 14 2 0", quotient, remainder, dz);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got %b want 0", done);
        end
    endtask

    task automatic test_div_zero();
        run_op(8'd5, 8'd0, "div_5_0");
        checks++;
        if (quotient !== 8'hFF || remainder !== 8'd5 || dz !== 1'b1) begin
            errors++;
            $display("FAIL div_zero_const got q=%h r=%h dz=%b want ff 05 1", quotient, remainder, dz);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        run_op(8'd255, 8'd1, "div_255_1");
        tick();
        run_op(8'd3, 8'd10, "div_3_10");
        tick();
        run_op(8'd255, 8'd255, "div_255_255");
        run_op(8'd77, 8'd6, "b2b_77_6");
        run_op(8'd9, 8'd0, "b2b_9_0");
        run_op(8'd200, 8'd3, "b2b_200_3");
        tick();
    endtask

    task automatic test_abort();
        int seen;
        dividend = 8'd200;
        divisor  = 8'd9;
        start    = 1'b1;
        tick();
        dividend = 8'd50;
        divisor  = 8'd5;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || quotient !== held_q) begin
            errors++;
            $display("FAIL ignore_start got busy=%b q=%h want 1 %h", busy, quotient, held_q);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, dz} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL abort_reset got busy=%b done=%b dz=%b q=%h r=%h want all 0", busy, done, dz, quotient, remainder);
        end
        seen = 0;
        for (int i = 0; i < 3 * W; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d active cycles want 0", seen);
        end
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0) begin
            errors++;
            $display("FAIL rst_beats_start got busy=%b done=%b q=%h want 0 0 00", busy, done, quotient);
        end
        held_q = '0;
        held_r = '0;
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        run_op(8'h9C, 8'd7, "s_m100_7");
        checks++;
        if (quotient !== 8'hF2 || remainder !== 8'hFE) begin
            errors++;
            $display("FAIL s_m100_7_const got q=%h r=%h want f2 fe", quotient, remainder);
        end
        run_op(8'd100, 8'hF9, "s_100_m7");
        checks++;
        if (quotient !== 8'hF2 || remainder !== 8'h02) begin
            errors++;
            $display("FAIL s_100_m7_const got q=%h r=%h want f2 02", quotient, remainder);
        end
        run_op(8'h80, 8'hFF, "s_m128_m1");
        checks++;
        if (quotient !== 8'h80 || remainder !== 8'h00 || dz !== 1'b0) begin
            errors++;
            $display("FAIL s_overflow got q=%h r=%h dz=%b want 80 00 0", quotient, remainder, dz);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           sel;
        for (int i = 0; i < 3000; i++) begin
            a   = W'($urandom);
            sel = $urandom_range(0, 15);
            if (sel == 0)      b = '0;
            else if (sel < 4)  b = W'($urandom_range(1, 4));
            else if (sel == 4) b = '1;
            else               b = W'($urandom);
            if (sel == 5) a = 8'h80;
            run_op(a, b, "random");
`ifndef DIV_SIGNED_EN
            if (b != '0) begin
                checks++;
                if (int'(quotient) * int'(b) + int'(remainder) != int'(a) || remainder >= b) begin
                    errors++;
                    $display("FAIL invariant %0d/%0d got q=%0d r=%0d", a, b, quotient, remainder);
                end
            end
`endif
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_abort();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
